// File: rtl/ysyx_23060187_ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one instruction read per instruction,
// hands the word to the IDU and waits for the writeback next-PC before fetching again.
module ysyx_23060187_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req_valid,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_req_ready,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    input  logic             mem_resp_err,
    output logic             mem_resp_ready,
    output logic [31:0]      IFU_inst,
    output logic [31:0]      IFU_pc,
    output logic             IFU_fault,
    output logic             IFU_IDU_valid,
    input  logic             IDU_IFU_ready,
    input  logic             WBU_IFU_valid,
    input  logic [31:0]      WBU_next_pc,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // A valid, once raised, holds its payload stable until that transfer.

    typedef enum logic [1:0] {
        S_REQ       = 2'd0,
        S_WAIT_RESP = 2'd1,
        S_SEND      = 2'd2,
        S_WAIT_PC   = 2'd3
    } state_t;

    localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_pc;
    logic [TO_W-1:0] r_to_cnt;
    logic [31:0]     r_inst;
    logic [31:0]     r_inst_pc;
    logic            r_fault;
    logic            r_valid;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_req_fire;
    logic w_resp_take;
    logic w_timeout;
    logic w_handshake;
    logic w_pc_load;

    always_comb begin
        w_state_nxt = r_state;
        w_req_fire  = 1'b0;
        w_resp_take = 1'b0;
        w_timeout   = 1'b0;
        w_handshake = 1'b0;
        w_pc_load   = 1'b0;
        case (r_state)
            S_REQ: begin
                if (mem_req_ready) begin
                    w_req_fire  = 1'b1;
                    w_state_nxt = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                // A response arriving on the last allowed cycle still beats the timeout.
                if (mem_resp_valid) begin
                    w_resp_take = 1'b1;
                    w_state_nxt = S_SEND;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (IDU_IFU_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = S_WAIT_PC;
                end
            end
            S_WAIT_PC: begin
                if (WBU_IFU_valid) begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_to_cnt    <= '0;
            r_inst      <= '0;
            r_inst_pc   <= '0;
            r_fault     <= 1'b0;
            r_valid     <= 1'b0;
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_pc_load) begin
                r_pc <= WBU_next_pc;
            end

            if (w_req_fire) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT_RESP && !w_resp_take && !w_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_resp_take) begin
                r_inst    <= mem_resp_data;
                r_inst_pc <= r_pc;
                r_fault   <= mem_resp_err;
                r_valid   <= 1'b1;
            end else if (w_timeout) begin
                r_inst    <= NOP;
                r_inst_pc <= r_pc;
                r_fault   <= 1'b1;
                r_valid   <= 1'b1;
            end else if (w_handshake) begin
                r_valid   <= 1'b0;
            end

            if (w_handshake) begin
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end
            if (r_state == S_REQ || r_state == S_WAIT_RESP) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_req_valid  = (r_state == S_REQ);
    assign mem_req_addr   = r_pc;
    assign mem_resp_ready = (r_state == S_WAIT_RESP);
    assign IFU_inst       = r_inst;
    assign IFU_pc         = r_inst_pc;
    assign IFU_fault      = r_fault;
    assign IFU_IDU_valid  = r_valid;
    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_ysyx_23060187_ifu_fetch.sv
// Bench for the fetch stage: the bench plays memory, IDU and WBU, and predicts every
// handed-over instruction, PC and counter from the stimulus it chose.
module tb_ysyx_23060187_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          TIMEOUT  = 16;
  localparam int          CNT_W    = 32;

  logic             clk;
  logic             rst;
  logic             mem_req_valid;
  logic [31:0]      mem_req_addr;
  logic             mem_req_ready;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_data;
  logic             mem_resp_err;
  logic             mem_resp_ready;
  logic [31:0]      IFU_inst;
  logic [31:0]      IFU_pc;
  logic             IFU_fault;
  logic             IFU_IDU_valid;
  logic             IDU_IFU_ready;
  logic             WBU_IFU_valid;
  logic [31:0]      WBU_next_pc;
  logic [CNT_W-1:0] perf_fetch_cnt;
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [1:0]       dbg_state;

  ysyx_23060187_ifu_fetch #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .mem_resp_ready (mem_resp_ready),
    .IFU_inst       (IFU_inst),
    .IFU_pc         (IFU_pc),
    .IFU_fault      (IFU_fault),
    .IFU_IDU_valid  (IFU_IDU_valid),
    .IDU_IFU_ready  (IDU_IFU_ready),
    .WBU_IFU_valid  (WBU_IFU_valid),
    .WBU_next_pc    (WBU_next_pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [64:0] exp_q[$];          // {fault, pc, inst} of each instruction the IDU should see
  logic [31:0] m_pc;              // PC the next fetch must use
  int          m_stall;           // REQ + WAIT_RESP cycles so far
  int          m_fetch;           // instructions handed over so far

  task automatic idle_inputs();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    mem_resp_err   = 1'b0;
    IDU_IFU_ready  = 1'b0;
    WBU_IFU_valid  = 1'b0;
    WBU_next_pc    = 32'h0;
  endtask

  // ---------------- driver: one complete fetch transaction ----------------
  // resp_dly >= TIMEOUT means memory never answers.
  task automatic run_fetch(input int req_dly, input int resp_dly, input logic [31:0] data,
                           input logic err, input int idu_dly, input int wb_dly,
                           input logic [31:0] next_pc);
    logic [64:0] exp;
    bit          answered;
    // request phase, with junk responses that must be ignored
    for (int i = 0; i <= req_dly; i++) begin
      n_cmp++;
      if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL req_valid: got %b want 1", mem_req_valid); end
      n_cmp++;
      if (mem_req_addr !== m_pc) begin n_fail++; $display("FAIL req_addr: got %h want %h", mem_req_addr, m_pc); end
      n_cmp++;
      if (mem_resp_ready !== 1'b0) begin n_fail++; $display("FAIL resp_ready_in_req: got %b want 0", mem_resp_ready); end
      mem_req_ready  = (i == req_dly);
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = $urandom;
      mem_resp_err   = 1'($urandom_range(0, 1));
      m_stall++;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    // response phase
    answered = 1'b0;
    for (int j = 0; j < TIMEOUT; j++) begin
      n_cmp++;
      if (mem_resp_ready !== 1'b1) begin n_fail++; $display("FAIL resp_ready: got %b want 1", mem_resp_ready); end
      n_cmp++;
      if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL req_valid_in_wait: got %b want 0", mem_req_valid); end
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = (j == resp_dly);
      mem_resp_data  = (j == resp_dly) ? data : $urandom;
      mem_resp_err   = (j == resp_dly) ? err : 1'($urandom_range(0, 1));
      m_stall++;
      if (j == resp_dly) answered = 1'b1;
      @(negedge clk);
      if (answered) break;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    exp = answered ? {err, m_pc, data} : {1'b1, m_pc, 32'h0000_0013};
    exp_q.push_back(exp);
    // hand-over phase; WBU pulses and memory noise here must change nothing
    exp = exp_q.pop_front();
    for (int k = 0; k <= idu_dly; k++) begin
      n_cmp++;
      if (IFU_IDU_valid !== 1'b1) begin n_fail++; $display("FAIL idu_valid: got %b want 1", IFU_IDU_valid); end
      n_cmp++;
      if (IFU_inst !== exp[31:0]) begin n_fail++; $display("FAIL idu_inst: got %h want %h", IFU_inst, exp[31:0]); end
      n_cmp++;
      if (IFU_pc !== exp[63:32]) begin n_fail++; $display("FAIL idu_pc: got %h want %h", IFU_pc, exp[63:32]); end
      n_cmp++;
      if (IFU_fault !== exp[64]) begin n_fail++; $display("FAIL idu_fault: got %b want %b", IFU_fault, exp[64]); end
      n_cmp++;
      if (perf_stall_cnt !== CNT_W'(m_stall)) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", perf_stall_cnt, m_stall); end
      n_cmp++;
      if (perf_fetch_cnt !== CNT_W'(m_fetch)) begin n_fail++; $display("FAIL fetch_cnt_send: got %0d want %0d", perf_fetch_cnt, m_fetch); end
      n_cmp++;
      if (mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin
        n_fail++; $display("FAIL mem_idle_send: got req %b resp %b want 0 0", mem_req_valid, mem_resp_ready);
      end
      IDU_IFU_ready  = (k == idu_dly);
      WBU_IFU_valid  = 1'($urandom_range(0, 1));
      WBU_next_pc    = $urandom;
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = $urandom;
      @(negedge clk);
    end
    IDU_IFU_ready = 1'b0;
    m_fetch++;
    // wait for writeback
    for (int w = 0; w <= wb_dly; w++) begin
      n_cmp++;
      if (IFU_IDU_valid !== 1'b0) begin n_fail++; $display("FAIL idu_valid_drop: got %b want 0", IFU_IDU_valid); end
      n_cmp++;
      if (perf_fetch_cnt !== CNT_W'(m_fetch)) begin n_fail++; $display("FAIL fetch_cnt: got %0d want %0d", perf_fetch_cnt, m_fetch); end
      n_cmp++;
      if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL req_valid_in_wait_pc: got %b want 0", mem_req_valid); end
      WBU_IFU_valid  = (w == wb_dly);
      WBU_next_pc    = (w == wb_dly) ? next_pc : $urandom;
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = $urandom;
      @(negedge clk);
    end
    idle_inputs();
    m_pc = next_pc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (IFU_IDU_valid !== 1'b0 || IFU_inst !== 32'h0 || IFU_pc !== 32'h0 || IFU_fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_idu: got v%b i%h p%h f%b want all zero", IFU_IDU_valid, IFU_inst, IFU_pc, IFU_fault);
    end
    n_cmp++;
    if (perf_fetch_cnt !== '0 || perf_stall_cnt !== '0) begin
      n_fail++; $display("FAIL reset_perf: got %0d %0d want 0 0", perf_fetch_cnt, perf_stall_cnt);
    end
    n_cmp++;
    if (mem_req_addr !== RESET_PC || mem_resp_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem: got addr %h rr %b want %h 0", mem_req_addr, mem_resp_ready, RESET_PC);
    end
    rst = 1'b1;
    m_pc = RESET_PC; m_stall = 0; m_fetch = 0;
  endtask

  task automatic test_basic_fetch();
    run_fetch(0, 0, 32'h0000_0297, 1'b0, 0, 0, 32'h8000_0004);
  endtask

  task automatic test_send_stall();
    run_fetch(0, 1, 32'h0010_0093, 1'b0, 5, 1, 32'h8000_0008);
    n_cmp++;
    if (perf_fetch_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL fetch_cnt_two: got %0d want 2", perf_fetch_cnt); end
  endtask

  task automatic test_next_pc();
    run_fetch(1, 2, 32'h0000_0513, 1'b0, 2, 3, 32'h8000_0010);
    n_cmp++;
    if (mem_req_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL next_pc: got %h want 80000010", mem_req_addr); end
  endtask

  task automatic test_bus_error();
    run_fetch(0, 3, 32'hDEAD_BEEF, 1'b1, 1, 0, 32'h8000_0020);
  endtask

  task automatic test_timeout();
    run_fetch(0, 1000, 32'h1234_5678, 1'b0, 0, 0, 32'h8000_0024);
    run_fetch(2, TIMEOUT - 1, 32'h0040_0113, 1'b0, 0, 0, 32'h8000_0028);
  endtask

  task automatic test_req_backpressure();
    run_fetch(3, 0, 32'h00A0_0593, 1'b0, 0, 2, 32'h8000_0103);
  endtask

  task automatic test_reset_mid();
    run_fetch(0, 0, 32'hCAFE_0001, 1'b0, 0, 0, 32'h8000_0200);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    n_cmp++;
    if (mem_resp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_wait_resp: got %b want 1", mem_resp_ready); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (IFU_inst !== 32'h0 || IFU_pc !== 32'h0 || IFU_IDU_valid !== 1'b0 || perf_stall_cnt !== '0 || perf_fetch_cnt !== '0) begin
      n_fail++; $display("FAIL async_reset: got i%h p%h v%b s%0d f%0d want zeros", IFU_inst, IFU_pc, IFU_IDU_valid, perf_stall_cnt, perf_fetch_cnt);
    end
    n_cmp++;
    if (mem_req_addr !== RESET_PC || mem_resp_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_mem: got %h rr %b want %h 0", mem_req_addr, mem_resp_ready, RESET_PC);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_req_valid !== 1'b1 || IFU_IDU_valid !== 1'b0) begin
      n_fail++; $display("FAIL late_resp_ignored: got req %b v %b want 1 0", mem_req_valid, IFU_IDU_valid);
    end
    mem_resp_valid = 1'b0;
    m_pc = RESET_PC; m_stall = 1; m_fetch = 0;
    run_fetch(0, 0, 32'h0000_0297, 1'b0, 0, 0, 32'h8000_0300);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_fetch($urandom_range(0, 4), $urandom_range(0, TIMEOUT + 3), $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_send_stall();
    test_next_pc();
    test_bus_error();
    test_timeout();
    test_req_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
